serial_tx: RTL

Parallel-in, serial-out framed transmitter: the sending end of the team's single-wire serial link. It accepts one data word through a valid/ready handshake and shifts it out LSB first on `tx_out`, framed by one low start bit and one high stop bit. Each bit is held for a programmable number of clock cycles. It sits between the parallel data path and the line pin, feeding the matching latch-based receive side.

---
 rtl/serial_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
`timescale 1ns/1ps
// serial_tx: framed parallel-to-serial transmitter.
// Accepts one word on a valid/ready handshake and sends a low start bit,
// DATA_W data bits LSB first and a high stop bit on tx_out. Each line bit
// is held for CLKS_PER_BIT clocks. All outputs come straight from flops.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic                tx_out_q, tx_out_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    // Last cycle of the current line bit; with one clock per bit this is
    // every cycle because BAUD_MAX is zero and the counter never moves.
    logic                bit_end;
    logic [DATA_W-1:0]   shift_nx;

    assign bit_end  = (baud_q == BAUD_MAX);
    assign shift_nx = shift_q >> 1;

    assign tx_ready = ready_q;
    assign tx_out   = tx_out_q;
    assign busy     = busy_q;

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            tx_out_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_out_q  <= tx_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle
    // ahead so the line changes on the edge that enters each bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        tx_out_d  = tx_out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d  = tx_data;
                    baud_d   = '0;
                    state_d  = START;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    tx_out_d = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    tx_out_d  = shift_q[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_cnt_q == BIT_MAX) begin
                        tx_out_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        // Shift once per bit period; the new LSB is the
                        // next bit to put on the line.
                        shift_d   = shift_nx;
                        tx_out_d  = shift_nx[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_d   = '0;
                    tx_out_d = 1'b1;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule
